crossing_scheduler: RTL and testbench

CROSSING_SCHEDULER -- requirements
Module: crossing_scheduler

---
 rtl/crossing_scheduler.sv | 110 +++++++++++
 tb/tb_crossing_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/crossing_scheduler.sv
// Pedestrian crossing light sequencer: RED -> RED_AMBER -> GREEN -> AMBER -> RED,
// with a latched crossing request that ends GREEN once its minimum time has elapsed.
module crossing_scheduler #(
  parameter int RED_T     = 4,
  parameter int RA_T      = 1,
  parameter int GREEN_MIN = 3,
  parameter int AMBER_T   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       button,
  output logic [2:0] lights,
  output logic       walk,
  output logic       pending,
  output logic [7:0] cycles
);

  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } state_t;

  localparam logic [7:0] L_RED_LAST   = 8'(RED_T - 1);
  localparam logic [7:0] L_RA_LAST    = 8'(RA_T - 1);
  localparam logic [7:0] L_GREEN_LAST = 8'(GREEN_MIN - 1);
  localparam logic [7:0] L_AMBER_LAST = 8'(AMBER_T - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic       r_pending;
  logic [7:0] r_cycles;
  logic       w_trans;
  logic       w_enter_red;
  logic       w_green_done;

  assign w_green_done = (r_cnt >= L_GREEN_LAST);
  assign w_trans      = (w_next != r_state);
  assign w_enter_red  = (r_state == AMBER) && (w_next == RED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RED;
    end else begin
      r_state <= w_next;
    end
  end

  // A button seen on the same edge counts as a request, so GREEN can end without waiting for the latch.
  always_comb begin
    w_next = r_state;
    if (enable) begin
      case (r_state)
        RED:       if (r_cnt == L_RED_LAST)   w_next = RED_AMBER;
        RED_AMBER: if (r_cnt == L_RA_LAST)    w_next = GREEN;
        GREEN:     if (w_green_done && (r_pending || button)) w_next = AMBER;
        AMBER:     if (r_cnt == L_AMBER_LAST) w_next = RED;
        default:   w_next = RED;
      endcase
    end
  end

  always_comb begin
    lights = 3'b100;
    walk   = 1'b0;
    case (r_state)
      RED:       begin lights = 3'b100; walk = 1'b1; end
      RED_AMBER: lights = 3'b110;
      GREEN:     lights = 3'b001;
      AMBER:     lights = 3'b010;
      default:   lights = 3'b100;
    endcase
  end

  // GREEN saturates at its minimum so an unbounded wait never wraps the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_trans) begin
      r_cnt <= '0;
    end else if (enable && !(r_state == GREEN && w_green_done)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_enter_red) begin
      r_pending <= 1'b0;
    end else if (button && r_state != RED) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_enter_red) begin
      r_cycles <= r_cycles + 8'd1;
    end
  end

  assign pending = r_pending;
  assign cycles  = r_cycles;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler at default timing parameters,
// with a per-cycle monitor on light legality and sequence order.
module tb_crossing_scheduler;

  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_RA = 3'b110;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_A  = 3'b010;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       button;
  logic [2:0] lights;
  logic       walk;
  logic       pending;
  logic [7:0] cycles;

  int errors;
  int checks;
  logic [2:0] prev_lights;

  crossing_scheduler #(
    .RED_T(4),
    .RA_T(1),
    .GREEN_MIN(3),
    .AMBER_T(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .button(button),
    .lights(lights),
    .walk(walk),
    .pending(pending),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] el, input logic ew, input logic ep);
    chk({tag, "_lights"}, {5'b0, lights}, {5'b0, el});
    chk({tag, "_walk"}, {7'b0, walk}, {7'b0, ew});
    chk({tag, "_pending"}, {7'b0, pending}, {7'b0, ep});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] succ(input logic [2:0] l);
    case (l)
      L_R:     return L_RA;
      L_RA:    return L_G;
      L_G:     return L_A;
      default: return L_R;
    endcase
  endfunction

  initial prev_lights = L_R;

  always @(negedge clk) begin
    if (rst) begin
      prev_lights = L_R;
    end else begin
      chk("mon_legal", {7'b0, (lights == L_R || lights == L_RA || lights == L_G || lights == L_A)}, 8'd1);
      if (lights !== prev_lights) chk("mon_order", {5'b0, lights}, {5'b0, succ(prev_lights)});
      prev_lights = lights;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    enable = 1'b1;
    button = 1'b0;

    #2;
    chk_st("reset", L_R, 1'b1, 1'b0);
    chk("reset_cycles", cycles, 8'd0);

    // Power-up: 4 RED, 1 RED_AMBER, then GREEN held with no request
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_st("pu_red0", L_R, 1'b1, 1'b0);
    repeat (3) begin tick(); chk_st("pu_red", L_R, 1'b1, 1'b0); end
    tick(); chk_st("pu_ra", L_RA, 1'b0, 1'b0);
    repeat (22) begin tick(); chk_st("pu_green", L_G, 1'b0, 1'b0); end
    chk("pu_cycles", cycles, 8'd0);

    // Late request: AMBER on the edge that samples the button
    button = 1'b1;
    tick(); chk_st("late_amber", L_A, 1'b0, 1'b1);
    button = 1'b0;
    tick(); chk_st("late_red", L_R, 1'b1, 1'b0);
    chk("late_cycles", cycles, 8'd1);

    // Button held through RED is ignored
    button = 1'b1;
    repeat (3) begin tick(); chk_st("ign_red", L_R, 1'b1, 1'b0); end
    button = 1'b0;
    tick(); chk_st("ign_ra", L_RA, 1'b0, 1'b0);

    // Freeze in RED_AMBER
    enable = 1'b0;
    repeat (5) begin tick(); chk_st("frz_ra", L_RA, 1'b0, 1'b0); end
    enable = 1'b1;
    tick(); chk_st("frz_green", L_G, 1'b0, 1'b0);

    // Early request on first GREEN cycle: GREEN lasts exactly 3 cycles
    button = 1'b1;
    tick(); chk_st("early_g1", L_G, 1'b0, 1'b1);
    button = 1'b0;
    tick(); chk_st("early_g2", L_G, 1'b0, 1'b1);
    tick(); chk_st("early_amber", L_A, 1'b0, 1'b1);
    tick(); chk_st("early_red", L_R, 1'b1, 1'b0);
    chk("early_cycles", cycles, 8'd2);

    // Freeze in RED, then RED still lasts 4 enabled cycles
    enable = 1'b0;
    repeat (3) begin tick(); chk_st("frz_red", L_R, 1'b1, 1'b0); end
    enable = 1'b1;
    repeat (3) begin tick(); chk_st("frz_red_run", L_R, 1'b1, 1'b0); end
    tick(); chk_st("frz_red_ra", L_RA, 1'b0, 1'b0);
    tick(); chk_st("frz_red_g", L_G, 1'b0, 1'b0);

    // Request latched while disabled; GREEN holds until enabled
    enable = 1'b0;
    button = 1'b1;
    tick(); chk_st("dis_latch", L_G, 1'b0, 1'b1);
    button = 1'b0;
    repeat (3) begin tick(); chk_st("dis_hold", L_G, 1'b0, 1'b1); end
    enable = 1'b1;
    tick(); chk_st("dis_g1", L_G, 1'b0, 1'b1);
    tick(); chk_st("dis_g2", L_G, 1'b0, 1'b1);
    tick(); chk_st("dis_amber", L_A, 1'b0, 1'b1);
    tick(); chk_st("dis_red", L_R, 1'b1, 1'b0);
    chk("dis_cycles", cycles, 8'd3);

    // Reach GREEN with a pending request, then reset between edges
    repeat (3) begin tick(); chk_st("pre_rst_red", L_R, 1'b1, 1'b0); end
    tick(); chk_st("pre_rst_ra", L_RA, 1'b0, 1'b0);
    tick(); chk_st("pre_rst_g", L_G, 1'b0, 1'b0);
    button = 1'b1;
    tick(); chk_st("pre_rst_pend", L_G, 1'b0, 1'b1);
    button = 1'b0;
    tick(); chk_st("pre_rst_g2", L_G, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_st("async", L_R, 1'b1, 1'b0);
    chk("async_cycles", cycles, 8'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin tick(); chk_st("post_rst_red", L_R, 1'b1, 1'b0); end
    tick(); chk_st("post_rst_ra", L_RA, 1'b0, 1'b0);
    tick(); chk_st("post_rst_g", L_G, 1'b0, 1'b0);
    chk("post_rst_cycles", cycles, 8'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
